// File: rtl/rf_multiport_pkg.sv
// Shared register-file constants for the integer core: address width, depth,
// the zero word/register and the stack-pointer reset value.
package rf_multiport_pkg;

    localparam int          REG_ADDR_WIDTH   = 5;
    localparam int          REG_NUM          = 2 ** REG_ADDR_WIDTH;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG_ADDR = '0;
    localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_003f;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on long-latency issue,
// cleared by writeback, masked on read ports when the clearing write is in flight.
module rf_scoreboard
    import rf_multiport_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     busy_set_en,
    input  logic [ADDR_W-1:0]        busy_set_addr,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_d;

    // Precedence, lowest to highest: writeback clear, new issue, flush.
    always_comb begin
        busy_d = busy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k]) begin
                busy_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (busy_set_en) begin
            busy_d[busy_set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_busy
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra = rd_addr[j*ADDR_W +: ADDR_W];

        always_comb begin
            hit = 1'b0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
                    hit = 1'b1;
                end
            end
        end

        // Data for a register being written this cycle arrives on the bypass path.
        assign rd_busy[j] = busy[ra] & ~hit;
    end

endmodule

// File: rtl/rf_multiport.sv
// Multi-port integer register file with same-cycle write-to-read bypass and a
// pending-write scoreboard for RAW stalls in decode.
module rf_multiport
    import rf_multiport_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = REG_ADDR_WIDTH,
    parameter int                NUM_RD   = 2,
    parameter int                NUM_WR   = 2,
    parameter int                SP_ADDR  = 2,
    parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     busy_set_en,
    input  logic [ADDR_W-1:0]        busy_set_addr,
    input  logic                     flush
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);
    localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZERO_WORD);

    logic [DATA_W-1:0] regs [DEPTH];

    // Write ports have no handshake: an enabled write always commits. Ports are
    // applied in ascending order so the highest index wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_ADDR) ? SP_RESET : ZERO_DATA;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
                    regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[j*ADDR_W +: ADDR_W];

        // Later ports overwrite earlier matches, matching the write-collision rule.
        always_comb begin
            val = regs[ra];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
                    val = wr_data[k*DATA_W +: DATA_W];
                end
            end
            if (ra == ZERO_ADDR) begin
                val = ZERO_DATA;
            end
        end

        assign rd_data[j*DATA_W +: DATA_W] = val;
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .flush         (flush),
        .rd_busy       (rd_busy)
    );

endmodule
